// File: rtl/rvfpm_result_buffer.sv
// Result buffer between FPU result producers and the XIF result port.
// Round-robin intake, age-ordered queue, commit/kill tracking, registered output.
module rvfpm_result_buffer #(
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 4,
  parameter int X_ID_WIDTH   = 4,
  parameter int FLEN         = 32,
  parameter int OUT_OF_ORDER = 0
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*X_ID_WIDTH-1:0] src_id,
  input  logic [NUM_SRC*FLEN-1:0]      src_data,
  input  logic [NUM_SRC*5-1:0]         src_rd,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [X_ID_WIDTH-1:0]        result_id,
  output logic [FLEN-1:0]              result_data,
  output logic [4:0]                   result_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NID = 2 ** X_ID_WIDTH;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [X_ID_WIDTH-1:0] q_id_q   [DEPTH];
  logic [X_ID_WIDTH-1:0] q_id_d   [DEPTH];
  logic [FLEN-1:0]       q_data_q [DEPTH];
  logic [FLEN-1:0]       q_data_d [DEPTH];
  logic [4:0]            q_rd_q   [DEPTH];
  logic [4:0]            q_rd_d   [DEPTH];
  logic [DEPTH-1:0]      q_cm_q, q_cm_d, q_kl_q, q_kl_d;
  logic [NID-1:0]        tbl_cm_q, tbl_cm_d, tbl_kl_q, tbl_kl_d;

  logic                  result_valid_q, result_valid_d;
  logic [X_ID_WIDTH-1:0] result_id_q, result_id_d;
  logic [FLEN-1:0]       result_data_q, result_data_d;
  logic [4:0]            result_rd_q, result_rd_d;

  logic                  cset_cm, cset_kl;
  logic [PW-1:0]         sel;
  logic                  sel_found;
  int unsigned           arb_idx;
  logic                  insert;
  logic [X_ID_WIDTH-1:0] ins_id;
  logic [FLEN-1:0]       ins_data;
  logic [4:0]            ins_rd;
  logic                  ins_cm, ins_kl;
  logic [IW-1:0]         ins_idx;

  logic                  cand_found, dead_found, load_ok;
  logic [IW-1:0]         cand_idx, dead_idx, rem_idx;
  logic                  do_load, do_dead, remove;
  logic [X_ID_WIDTH-1:0] rem_id;
  logic [DEPTH-1:0]      upd_cm, upd_kl;

  assign cset_cm = commit_valid && !commit_kill;
  assign cset_kl = commit_valid && commit_kill;

  // Round-robin search starting at rr_ptr; ready is gated by reset and fullness.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    arb_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!sel_found && src_valid[arb_idx]) begin
        sel       = PW'(arb_idx);
        sel_found = 1'b1;
      end
    end
    src_ready = '0;
    insert    = 1'b0;
    if (rst && sel_found && (count_q < CW'(DEPTH))) begin
      src_ready[sel] = 1'b1;
      insert         = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (insert) begin
      rr_ptr_d = (int'(sel) == NUM_SRC - 1) ? '0 : sel + PW'(1);
    end
    ins_id   = src_id[sel*X_ID_WIDTH +: X_ID_WIDTH];
    ins_data = src_data[sel*FLEN +: FLEN];
    ins_rd   = src_rd[sel*5 +: 5];
    ins_cm   = tbl_cm_q[ins_id] || (cset_cm && (commit_id == ins_id));
    ins_kl   = tbl_kl_q[ins_id] || (cset_kl && (commit_id == ins_id));
  end

  // Removal candidate selection uses registered flags, so a commit or kill
  // takes effect on the edge after it is seen.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    dead_found = 1'b0;
    dead_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) begin
        if (!cand_found && q_cm_q[i] && !q_kl_q[i] && ((OUT_OF_ORDER != 0) || (i == 0))) begin
          cand_found = 1'b1;
          cand_idx   = IW'(i);
        end
        if (!dead_found && q_kl_q[i]) begin
          dead_found = 1'b1;
          dead_idx   = IW'(i);
        end
      end
    end
    load_ok = !result_valid_q || result_ready;
    do_load = load_ok && cand_found;
    do_dead = !do_load && dead_found;
    remove  = do_load || do_dead;
    rem_idx = do_load ? cand_idx : dead_idx;
    rem_id  = q_id_q[rem_idx];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd_cm[i] = q_cm_q[i] || (cset_cm && (q_id_q[i] == commit_id));
      upd_kl[i] = q_kl_q[i] || (cset_kl && (q_id_q[i] == commit_id));
    end
    for (int i = 0; i < DEPTH; i++) begin
      q_id_d[i]   = q_id_q[i];
      q_data_d[i] = q_data_q[i];
      q_rd_d[i]   = q_rd_q[i];
    end
    q_cm_d = upd_cm;
    q_kl_d = upd_kl;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (remove && (i >= int'(rem_idx))) begin
        q_id_d[i]   = q_id_q[i+1];
        q_data_d[i] = q_data_q[i+1];
        q_rd_d[i]   = q_rd_q[i+1];
        q_cm_d[i]   = upd_cm[i+1];
        q_kl_d[i]   = upd_kl[i+1];
      end
    end
    ins_idx = IW'(count_q - CW'(remove));
    if (insert) begin
      q_id_d[ins_idx]   = ins_id;
      q_data_d[ins_idx] = ins_data;
      q_rd_d[ins_idx]   = ins_rd;
      q_cm_d[ins_idx]   = ins_cm;
      q_kl_d[ins_idx]   = ins_kl;
    end
    count_d = count_q + CW'(insert) - CW'(remove);

    // Clear on departure first so a same-cycle commit to that ID still lands.
    tbl_cm_d = tbl_cm_q;
    tbl_kl_d = tbl_kl_q;
    if (remove) begin
      tbl_cm_d[rem_id] = 1'b0;
      tbl_kl_d[rem_id] = 1'b0;
    end
    if (cset_cm) tbl_cm_d[commit_id] = 1'b1;
    if (cset_kl) tbl_kl_d[commit_id] = 1'b1;
  end

  always_comb begin
    result_valid_d = result_valid_q;
    result_id_d    = result_id_q;
    result_data_d  = result_data_q;
    result_rd_d    = result_rd_q;
    if (do_load) begin
      result_valid_d = 1'b1;
      result_id_d    = q_id_q[rem_idx];
      result_data_d  = q_data_q[rem_idx];
      result_rd_d    = q_rd_q[rem_idx];
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      rr_ptr_q       <= '0;
      count_q        <= '0;
      q_cm_q         <= '0;
      q_kl_q         <= '0;
      tbl_cm_q       <= '0;
      tbl_kl_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_data_q  <= '0;
      result_rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_id_q[i]   <= '0;
        q_data_q[i] <= '0;
        q_rd_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      count_q        <= count_d;
      q_cm_q         <= q_cm_d;
      q_kl_q         <= q_kl_d;
      tbl_cm_q       <= tbl_cm_d;
      tbl_kl_q       <= tbl_kl_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_data_q  <= result_data_d;
      result_rd_q    <= result_rd_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_id_q[i]   <= q_id_d[i];
        q_data_q[i] <= q_data_d[i];
        q_rd_q[i]   <= q_rd_d[i];
      end
    end
  end

  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
  assign result_data  = result_data_q;
  assign result_rd    = result_rd_q;
  assign count        = count_q;

endmodule

// File: tb/tb_rvfpm_result_buffer.sv
// Scoreboard bench: in-order and out-of-order instances share one stimulus stream;
// each has its own expected-result queue and monitor.
module tb_rvfpm_result_buffer;
  localparam int NS = 2;
  localparam int D  = 4;
  localparam int XW = 4;
  localparam int FL = 32;

  logic ck = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  logic [NS-1:0]    src_valid;
  logic [NS*XW-1:0] src_id;
  logic [NS*FL-1:0] src_data;
  logic [NS*5-1:0]  src_rd;
  logic             commit_valid, commit_kill, result_ready;
  logic [XW-1:0]    commit_id;

  logic [NS-1:0] rdy0, rdy1;
  logic          rv0, rv1;
  logic [XW-1:0] rid0, rid1;
  logic [FL-1:0] rdat0, rdat1;
  logic [4:0]    rrd0, rrd1;
  logic [2:0]    cnt0, cnt1;

  rvfpm_result_buffer #(.NUM_SRC(NS), .DEPTH(D), .X_ID_WIDTH(XW), .FLEN(FL), .OUT_OF_ORDER(0)) dut0 (
    .ck(ck), .rst(rst), .src_valid(src_valid), .src_ready(rdy0), .src_id(src_id),
    .src_data(src_data), .src_rd(src_rd), .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_kill(commit_kill), .result_valid(rv0), .result_ready(result_ready),
    .result_id(rid0), .result_data(rdat0), .result_rd(rrd0), .count(cnt0));

  rvfpm_result_buffer #(.NUM_SRC(NS), .DEPTH(D), .X_ID_WIDTH(XW), .FLEN(FL), .OUT_OF_ORDER(1)) dut1 (
    .ck(ck), .rst(rst), .src_valid(src_valid), .src_ready(rdy1), .src_id(src_id),
    .src_data(src_data), .src_rd(src_rd), .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_kill(commit_kill), .result_valid(rv1), .result_ready(result_ready),
    .result_id(rid1), .result_data(rdat1), .result_rd(rrd1), .count(cnt1));

  typedef struct packed {
    logic [XW-1:0] id;
    logic [FL-1:0] data;
    logic [4:0]    rd;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t m0, m1;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  always @(negedge ck) begin
    if (rst && rv0 && result_ready) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL out0_unexpected: got id %0h, want no output", rid0);
      end else begin
        m0 = exp0.pop_front();
        check("out0", {23'd0, rid0, rdat0, rrd0}, {23'd0, m0.id, m0.data, m0.rd});
      end
    end
  end

  always @(negedge ck) begin
    if (rst && rv1 && result_ready) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL out1_unexpected: got id %0h, want no output", rid1);
      end else begin
        m1 = exp1.pop_front();
        check("out1", {23'd0, rid1, rdat1, rrd1}, {23'd0, m1.id, m1.data, m1.rd});
      end
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    src_valid    = '0;
    src_id       = '0;
    src_data     = '0;
    src_rd       = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic put(input int s, input logic [XW-1:0] id, input logic [FL-1:0] d, input logic [4:0] rd);
    src_valid             = '0;
    src_valid[s]          = 1'b1;
    src_id[s*XW +: XW]    = id;
    src_data[s*FL +: FL]  = d;
    src_rd[s*5 +: 5]      = rd;
    tick();
    src_valid = '0;
  endtask

  task automatic commit(input logic [XW-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic push(input int which, input logic [XW-1:0] id, input logic [FL-1:0] d, input logic [4:0] rd);
    exp_t e;
    e.id = id; e.data = d; e.rd = rd;
    if (which != 1) exp0.push_back(e);
    if (which != 0) exp1.push_back(e);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((cnt0 != 0 || rv0 || cnt1 != 0 || rv1) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_cnt0", cnt0, 0);
    check("drain_cnt1", cnt1, 0);
    check("drain_rv0", rv0, 0);
    check("drain_rv1", rv1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1;
    idle();
    result_ready = 1'b0;
    src_valid    = 2'b11;
    #1;
    check("rst_src_ready", rdy0, 0);
    check("rst_valid", rv0, 0);
    check("rst_count", cnt0, 0);
    check("rst_id", rid0, 0);
    do_reset();

    // basic release: commit first, then the result
    result_ready = 1'b1;
    commit(4'd3, 1'b0);
    push(2, 4'd3, 32'h3F80_0000, 5'd5);
    src_valid     = 2'b01;
    src_id[3:0]   = 4'd3;
    src_data[31:0] = 32'h3F80_0000;
    src_rd[4:0]   = 5'd5;
    #1;
    check("basic_ready", rdy0, 2'b01);
    tick();
    src_valid = '0;
    check("basic_valid_n", rv0, 0);
    check("basic_count_n", cnt0, 1);
    tick();
    check("basic_valid_n1", rv0, 1);
    check("basic_count_n1", cnt0, 0);
    tick();
    check("basic_pulse", rv0, 0);
    check("basic_count_end", cnt0, 0);

    // arbitration and full
    do_reset();
    n0 = 0; n1 = 0;
    for (int g = 0; g < 4; g++) begin
      src_valid       = 2'b11;
      src_id[3:0]     = 4'(8 + n0);
      src_id[7:4]     = 4'(12 + n1);
      src_data[31:0]  = 32'(8 + n0) + 32'h100;
      src_data[63:32] = 32'(12 + n1) + 32'h100;
      src_rd[4:0]     = 5'(8 + n0);
      src_rd[9:5]     = 5'(12 + n1);
      #1;
      check("arb_grant0", rdy0, (g % 2 == 0) ? 2'b01 : 2'b10);
      check("arb_grant1", rdy1, (g % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (g % 2 == 0) n0++; else n1++;
    end
    src_id[3:0] = 4'd10;
    src_id[7:4] = 4'd14;
    #1;
    check("full_count", cnt0, 4);
    check("full_ready", rdy0, 2'b00);
    commit_valid = 1'b1;
    commit_id    = 4'd8;
    #1;
    check("full_ready_commit", rdy0, 2'b00);
    tick();
    commit_valid = 1'b0;
    check("full_ready_removal", rdy0, 2'b00);
    check("full_count_removal", cnt0, 4);
    push(2, 4'd8, 32'h108, 5'd8);
    tick();
    src_valid = '0;
    check("full_count_after", cnt0, 3);
    check("full_valid_after", rv0, 1);
    push(2, 4'd12, 32'h10C, 5'd12);
    push(2, 4'd9,  32'h109, 5'd9);
    push(2, 4'd13, 32'h10D, 5'd13);
    commit(4'd12, 1'b0);
    commit(4'd9, 1'b0);
    commit(4'd13, 1'b0);
    wait_drain(20);

    // kill
    do_reset();
    result_ready = 1'b1;
    put(0, 4'd1, 32'hA1, 5'd1);
    put(0, 4'd2, 32'hA2, 5'd2);
    put(0, 4'd3, 32'hA3, 5'd3);
    check("kill_count", cnt0, 3);
    push(2, 4'd1, 32'hA1, 5'd1);
    push(2, 4'd3, 32'hA3, 5'd3);
    commit(4'd2, 1'b1);
    commit(4'd1, 1'b0);
    commit(4'd3, 1'b0);
    wait_drain(20);

    // in-order blocking vs out-of-order release
    do_reset();
    result_ready = 1'b1;
    put(0, 4'd4, 32'hB4, 5'd4);
    put(0, 4'd5, 32'hB5, 5'd5);
    push(1, 4'd5, 32'hB5, 5'd5);
    commit(4'd5, 1'b0);
    tick();
    check("ooo_release", rv1, 1);
    check("ino_block", rv0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ino_block_hold", rv0, 0);
    end
    check("ino_block_count", cnt0, 2);
    push(0, 4'd4, 32'hB4, 5'd4);
    push(0, 4'd5, 32'hB5, 5'd5);
    push(1, 4'd4, 32'hB4, 5'd4);
    commit(4'd4, 1'b0);
    wait_drain(20);

    // backpressure then reset mid-stream
    do_reset();
    result_ready = 1'b0;
    commit(4'd7, 1'b0);
    put(0, 4'd7, 32'hDEAD_BEEF, 5'd9);
    tick();
    check("bp_valid", rv0, 1);
    put(0, 4'd6, 32'hC6, 5'd6);
    for (int k = 0; k < 10; k++) begin
      check("bp_id", rid0, 4'd7);
      check("bp_data", rdat0, 32'hDEAD_BEEF);
      tick();
    end
    check("bp_count", cnt0, 1);
    #2;
    rst          = 1'b0;
    src_valid    = 2'b01;
    src_id[3:0]  = 4'd9;
    #1;
    check("mid_rst_valid", rv0, 0);
    check("mid_rst_count", cnt0, 0);
    check("mid_rst_ready", rdy0, 0);
    check("mid_rst_valid1", rv1, 0);
    idle();
    tick();
    rst = 1'b1;
    result_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post_rst_quiet", {rv1, rv0}, 2'b00);
    end

    check("exp0_left", exp0.size(), 0);
    check("exp1_left", exp1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
